ball_physics: RTL
=================

Name: ball_physics

Overview:
- Per-frame ball dynamics integrator feeding the top-level renderer.
- Consumes signed tilt terms (sin_x/sin_y, derived from SW/BUTTON board angle) and a once-per-frame tick from VGA sync.
- Produces ball velocity and position consumed by the pixel generator and debug LEDs.
- Multi-cycle FSM: updates X then Y, clamps at walls with bounce.

Parameters:
- W, 11, datapath width for tilt, velocity, position.
- ACC_SHIFT, 4, acceleration = tilt >>> ACC_SHIFT (arithmetic).
- VMAX, 64, velocity magnitude saturation limit.
- X_MIN, 8, left wall (ball centre).
- X_MAX, 632, right wall.
- Y_MIN, 8, top wall.
- Y_MAX, 472, bottom wall.
- X_INIT, 320, reset/respawn X.
- Y_INIT, 240, reset/respawn Y.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame; starts an update
- respawn  in  1  synchronous reload of init state
- freeze  in  1  pause; ticks ignored while high
- sin_x  in  W  signed two's-complement tilt X
- sin_y  in  W  signed tilt Y
- velocity_x  out  W  signed
- velocity_y  out  W  signed
- position_x  out  W  unsigned
- position_y  out  W  unsigned
- busy  out  1  high while the FSM is not IDLE
- update_done  out  1  one-cycle pulse when both axes are updated
- wall_hit  out  4  sticky-per-update flags {top,bottom,left,right}

Behaviour:
- Reset (rst=0, async): state IDLE; velocity_x/y=0; position_x=X_INIT; position_y=Y_INIT; busy=0; update_done=0; wall_hit=0.
- FSM: IDLE -> CALC_X -> CALC_Y -> DONE -> IDLE.
- IDLE->CALC_X on frame_tick=1 and freeze=0. sin_x/sin_y are sampled into registers on that edge; later input changes do not affect the update.
- CALC_X: a = sx >>> ACC_SHIFT; v = sat(vx + a, ±VMAX); p = px + v, computed signed at W+1 bits.
  - If p < X_MIN: px=X_MIN, vx=-v, left flag set.
  - If p > X_MAX: px=X_MAX, vx=-v, right flag set.
  - Otherwise px=p, vx=v.
  - wall_hit is cleared at entry to CALC_X.
- CALC_Y: identical using Y params and sy; top flag for p < Y_MIN, bottom flag for p > Y_MAX.
- DONE: update_done=1 for exactly one cycle; then IDLE.
- busy=1 in CALC_X, CALC_Y and DONE.
- Latency: tick at edge 0 -> X valid after edge 1, Y valid after edge 2, update_done high during cycle 3.
- frame_tick while busy: ignored, not queued.
- respawn has priority in any state: next edge forces IDLE and init values, clears wall_hit, and suppresses update_done. Not blocked by freeze.
- freeze=1 mid-update: the current update completes; only new starts are blocked.
- Velocity saturates, never wraps. -VMAX..VMAX is symmetric, so negation cannot overflow.
- Simultaneous frame_tick and respawn: respawn wins and the tick is dropped.

Optional Feature:
- Macro: BALL_FRICTION_EN.
- Defined: before acceleration each axis velocity moves 1 toward zero (v>0: v-1; v<0: v+1; 0 stays 0), then a is added and saturated.
- Undefined: no decay; behaviour exactly as above.
- Test values below assume undefined.

Test Plan:
- Reset, then sin_x=160, sin_y=0, one tick -> vx=10, px=330, vy=0, py=240; update_done pulses 3 cycles after tick; second tick -> vx=20, px=350.
- sin_x=1023 (a=63), two ticks -> vx=63 then 64 (saturated); px=383 then 447.
- Preload via ticks to px=625, vx=20, tick -> px=632, vx=-20, wall_hit=0001. sin_y=-160 from init repeatedly -> py clamps at 8, vy positive, wall_hit=1000.
- frame_tick on cycles 0 and 1 -> exactly one update and one update_done; freeze=1 with tick -> no state change, busy stays 0.
- respawn asserted during CALC_Y -> next cycle IDLE, pos=(320,240), vel=0, no update_done. rst low mid-update -> immediate reset values.
- With BALL_FRICTION_EN: vx=10, sin_x=0, tick -> vx=9, px advanced by 9.

Source files
------------

// File: rtl/ball_physics_if.sv
// Ball physics port bundle: tilt/tick controls in, kinematic state out.
// The slave modport is the integrator side, the master the frame driver.
interface ball_physics_if #(
  parameter int W = 11
);
  logic         frame_tick;
  logic         respawn;
  logic         freeze;
  logic [W-1:0] sin_x;
  logic [W-1:0] sin_y;
  logic [W-1:0] velocity_x;
  logic [W-1:0] velocity_y;
  logic [W-1:0] position_x;
  logic [W-1:0] position_y;
  logic         busy;
  logic         update_done;
  logic [3:0]   wall_hit;

  modport master (
    output frame_tick, respawn, freeze,
    output sin_x, sin_y,
    input  velocity_x, velocity_y,
    input  position_x, position_y,
    input  busy, update_done, wall_hit
  );

  modport slave (
    input  frame_tick, respawn, freeze,
    input  sin_x, sin_y,
    output velocity_x, velocity_y,
    output position_x, position_y,
    output busy, update_done, wall_hit
  );
endinterface

// File: rtl/ball_physics.sv
// Per-frame ball integrator: X then Y, wall clamp with bounce.
// Optional 1-LSB velocity decay per update under BALL_FRICTION_EN.
module ball_physics #(
  parameter int W         = 11,
  parameter int ACC_SHIFT = 4,
  parameter int VMAX      = 64,
  parameter int X_MIN     = 8,
  parameter int X_MAX     = 632,
  parameter int Y_MIN     = 8,
  parameter int Y_MAX     = 472,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240
) (
  input logic           clk,
  input logic           rst,
  ball_physics_if.slave bus
);

  typedef logic signed [W-1:0] sw_t;
  typedef logic signed [W:0]   sx_t;

  typedef struct packed {
    logic [W-1:0] v;
    logic [W-1:0] p;
    logic         lo;
    logic         hi;
  } axis_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC_X,
    CALC_Y,
    DONE
  } state_t;

  localparam sx_t VMAX_W = sx_t'(VMAX);
  localparam sx_t XMIN_W = sx_t'(X_MIN);
  localparam sx_t XMAX_W = sx_t'(X_MAX);
  localparam sx_t YMIN_W = sx_t'(Y_MIN);
  localparam sx_t YMAX_W = sx_t'(Y_MAX);
  localparam logic [W-1:0] XINI_W = W'(X_INIT);
  localparam logic [W-1:0] YINI_W = W'(Y_INIT);

  // One axis step; position is widened by a bit so a wall overshoot
  // is still seen with the correct sign before clamping.
  function automatic axis_t axis_step(
    input sw_t          v_in,
    input logic [W-1:0] p_in,
    input sw_t          s,
    input sx_t          lo,
    input sx_t          hi
  );
    sw_t   a;
    sw_t   v0;
    sw_t   vs;
    sx_t   sum;
    sx_t   p;
    axis_t r;
    a  = s >>> ACC_SHIFT;
    v0 = v_in;
`ifdef BALL_FRICTION_EN
    if (v0[W-1])
      v0 = v0 + sw_t'(1);
    else if (v0 != '0)
      v0 = v0 - sw_t'(1);
`endif
    sum = sx_t'(v0) + sx_t'(a);
    if (sum > VMAX_W)
      vs = sw_t'(VMAX_W);
    else if (sum < -VMAX_W)
      vs = sw_t'(-VMAX_W);
    else
      vs = sum[W-1:0];
    p    = sx_t'({1'b0, p_in}) + sx_t'(vs);
    r.v  = vs;
    r.p  = p[W-1:0];
    r.lo = 1'b0;
    r.hi = 1'b0;
    if (p < lo) begin
      r.p  = lo[W-1:0];
      r.v  = -vs;
      r.lo = 1'b1;
    end else if (p > hi) begin
      r.p  = hi[W-1:0];
      r.v  = -vs;
      r.hi = 1'b1;
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  sw_t          vx_q, vx_d;
  sw_t          vy_q, vy_d;
  logic [W-1:0] px_q, px_d;
  logic [W-1:0] py_q, py_d;
  sw_t          sx_q, sx_d;
  sw_t          sy_q, sy_d;
  logic [3:0]   wh_q, wh_d;

  axis_t ax;
  axis_t ay;

  always_comb begin
    ax = axis_step(vx_q, px_q, sx_q, XMIN_W, XMAX_W);
    ay = axis_step(vy_q, py_q, sy_q, YMIN_W, YMAX_W);
  end

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    px_d    = px_q;
    py_d    = py_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    wh_d    = wh_q;
    unique case (state_q)
      IDLE: begin
        if (bus.frame_tick && !bus.freeze) begin
          state_d = CALC_X;
          sx_d    = bus.sin_x;
          sy_d    = bus.sin_y;
          wh_d    = '0;
        end
      end
      CALC_X: begin
        state_d = CALC_Y;
        vx_d    = ax.v;
        px_d    = ax.p;
        wh_d[1] = ax.lo;
        wh_d[0] = ax.hi;
      end
      CALC_Y: begin
        state_d = DONE;
        vy_d    = ay.v;
        py_d    = ay.p;
        wh_d[3] = ay.lo;
        wh_d[2] = ay.hi;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Respawn overrides any in-flight update, including a same-cycle tick.
    if (bus.respawn) begin
      state_d = IDLE;
      vx_d    = '0;
      vy_d    = '0;
      px_d    = XINI_W;
      py_d    = YINI_W;
      wh_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vx_q    <= '0;
      vy_q    <= '0;
      px_q    <= XINI_W;
      py_q    <= YINI_W;
      sx_q    <= '0;
      sy_q    <= '0;
      wh_q    <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      wh_q    <= wh_d;
    end
  end

  assign bus.velocity_x  = vx_q;
  assign bus.velocity_y  = vy_q;
  assign bus.position_x  = px_q;
  assign bus.position_y  = py_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.update_done = (state_q == DONE);
  assign bus.wall_hit    = wh_q;

endmodule
